bcd_to_bin_32: RTL

Iterative BCD-to-binary converter: the inverse of the team's 32-bit binary-to-BCD block. It accepts a 10-digit packed BCD word over a valid/ready handshake and converts it with reverse double-dabble, one bit per clock. It returns the low 32 bits of the result with overflow and invalid-digit flags over a second valid/ready handshake. It sits between BCD-entry or display-side logic and binary arithmetic datapaths.

---
 rtl/bcd_to_bin_32_if.sv | 34 +++
 rtl/bcd_to_bin_32.sv | 97 +++++++++
 2 files changed

// File: rtl/bcd_to_bin_32_if.sv
// Handshake bundle for the BCD-to-binary converter.
// master drives the BCD word and result-ready; slave returns result, flags and valids.
interface bcd_to_bin_32_if;
  logic [39:0] bcd_data_i;
  logic        bcd_data_valid_i;
  logic        bcd_redy_o;
  logic [31:0] bin_data_o;
  logic        bin_ovf_o;
  logic        bcd_err_o;
  logic        bin_data_valid_o;
  logic        bin_redy_i;

  modport master (
    output bcd_data_i,
    output bcd_data_valid_i,
    output bin_redy_i,
    input  bcd_redy_o,
    input  bin_data_o,
    input  bin_ovf_o,
    input  bcd_err_o,
    input  bin_data_valid_o
  );

  modport slave (
    input  bcd_data_i,
    input  bcd_data_valid_i,
    input  bin_redy_i,
    output bcd_redy_o,
    output bin_data_o,
    output bin_ovf_o,
    output bcd_err_o,
    output bin_data_valid_o
  );
endinterface

// File: rtl/bcd_to_bin_32.sv
// Iterative 10-digit BCD to 32-bit binary converter (reverse double-dabble).
// Ports: clk_i, rstn_i (async low), bus = slave side of bcd_to_bin_32_if.
module bcd_to_bin_32 (
  input  logic             clk_i,
  input  logic             rstn_i,
  bcd_to_bin_32_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    CONVERT  = 2'b01,
    COMPLETE = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [39:0] bcd_q, bcd_d;
  logic [33:0] bin_q, bin_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        redy;
  logic        accept;

  // Digits that were >=8 after the right shift held >=16 before it;
  // subtracting 3 undoes the decimal carry that the shift split.
  function automatic logic [39:0] adjust(input logic [39:0] v);
    logic [39:0] r;
    r = v;
    for (int k = 0; k < 10; k++) begin
      if (v[4*k+3]) r[4*k +: 4] = v[4*k +: 4] - 4'd3;
    end
    return r;
  endfunction

  function automatic logic bad_digit(input logic [39:0] v);
    logic b;
    b = 1'b0;
    for (int k = 0; k < 10; k++) begin
      b = b | (v[4*k+3] & (v[4*k+2] | v[4*k+1]));
    end
    return b;
  endfunction

  assign redy   = (state_q == IDLE) && rstn_i;
  assign accept = redy && bus.bcd_data_valid_i;

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          bcd_d   = bus.bcd_data_i;
          bin_d   = '0;
          cnt_d   = '0;
          err_d   = bad_digit(bus.bcd_data_i);
          state_d = err_d ? COMPLETE : CONVERT;
        end
      end
      CONVERT: begin
        bin_d = {bcd_q[0], bin_q[33:1]};
        bcd_d = adjust({1'b0, bcd_q[39:1]});
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd33) state_d = COMPLETE;
      end
      COMPLETE: begin
        if (bus.bin_redy_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.bcd_redy_o       = redy;
  assign bus.bin_data_o       = bin_q[31:0];
  assign bus.bin_ovf_o        = |bin_q[33:32];
  assign bus.bcd_err_o        = err_q;
  assign bus.bin_data_valid_o = (state_q == COMPLETE);

endmodule
